sum_accumulator: RTL



---
 rtl/sum_acc_pkg.sv | 14 +
 rtl/sum_acc_add.sv | 23 ++
 rtl/sum_accumulator.sv | 105 ++++++++++
 3 files changed

// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared state encoding and default widths for sum_accumulator
package sum_acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int SUM_W = 65;
  localparam int ACC_W = 72;
  localparam int CNT_W = 16;

endpackage

// File: rtl/sum_acc_add.sv
// rtl/sum_acc_add.sv - accumulator add with carry-out; SUM_ACCUMULATOR_SATURATE_EN clamps on overflow
module sum_acc_add #(
  parameter int ACC_W = sum_acc_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] next_acc,
  output logic             carry
);

  logic [ACC_W-1:0] raw_sum;

  always_comb begin
    {carry, raw_sum} = {1'b0, acc} + {1'b0, addend};
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further non-zero addend carries again, so all-ones holds.
    next_acc = carry ? {ACC_W{1'b1}} : raw_sum;
`else
    next_acc = raw_sum;
`endif
  end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates {cout,sum} beats and emits one total per flush
module sum_accumulator #(
  parameter int WIDTH = sum_acc_pkg::SUM_W,
  parameter int ACC_W = sum_acc_pkg::ACC_W,
  parameter int CNT_W = sum_acc_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  import sum_acc_pkg::*;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             beat;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] next_acc;
  logic             carry;

  assign in_ready = (state_q != S_DRAIN);
  assign beat     = in_valid & in_ready;
  assign addend   = ACC_W'({in_cout, in_sum});

  sum_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc      (acc_q),
    .addend   (addend),
    .next_acc (next_acc),
    .carry    (carry)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (beat) begin
          acc_d   = next_acc;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          ovf_d   = ovf_q | carry;
          state_d = S_ACCUM;
        end
        // A beat in the flush cycle lands in acc_d above, so it is part of the result.
        if (flush) begin
          state_d     = S_DRAIN;
          out_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The result registers only change in DRAIN on the handshake, which keeps them stable.
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule
